pc_fetch_ctrl: RTL and testbench

// - Multi-cycle fetch/PC sequencer for the MIPS core. Owns the PC register and the

---
 rtl/pc_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: multi-cycle PC/fetch sequencer; define ALIGN_CHECK_EN to trap misaligned jr to EXC_VEC
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0180
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        branch_en,
    input  logic [31:0] branch_off,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    output logic        flush,
    output logic        addr_err
);
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d;
    logic        flush_q, flush_d, addr_err_q, addr_err_d;
    logic [31:0] jump_tgt, branch_tgt, jr_tgt, redirect_tgt;
    logic        misaligned, redirect;

    assign pc_plus4    = pc_q + 32'd4;
    assign imem_req    = state_q == FETCH;
    assign imem_addr   = pc_q;
    assign instr_valid = state_q == ISSUE;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign flush       = flush_q;
    assign addr_err    = addr_err_q;

`ifdef ALIGN_CHECK_EN
    assign misaligned = jr_en && (jr_addr[1:0] != 2'b00);
`else
    logic unused_jr_lo;
    assign unused_jr_lo = ^jr_addr[1:0];
    assign misaligned   = 1'b0;
`endif

    // candidate targets and priority select: trap > jr > jump > branch > sequential
    always_comb begin
        jump_tgt     = {pc_plus4[31:28], jump_index, 2'b00};
        branch_tgt   = pc_plus4 + {branch_off[29:0], 2'b00};
        jr_tgt       = {jr_addr[31:2], 2'b00};
        redirect     = misaligned || jr_en || jump_en || branch_en;
        redirect_tgt = misaligned ? EXC_VEC : jr_en ? jr_tgt : jump_en ? jump_tgt : branch_en ? branch_tgt : pc_plus4;
    end

    // sequencer: boot, fetch until ack, issue until decode accepts
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        flush_d    = 1'b0;
        addr_err_d = 1'b0;
        if (state_q == BOOT) begin
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            state_d = imem_ack ? ISSUE : FETCH;
            instr_d = imem_ack ? imem_rdata : instr_q;
        end else if (state_q == ISSUE) begin
            state_d    = stall ? ISSUE : FETCH;
            pc_d       = stall ? pc_q : redirect_tgt;
            flush_d    = !stall && redirect;
            addr_err_d = !stall && misaligned;
        end else begin
            state_d = BOOT;
        end
    end

    // state registers; reset abandons any fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            instr_q    <= 32'd0;
            flush_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            flush_q    <= flush_d;
            addr_err_q <= addr_err_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and randomized bench for pc_fetch_ctrl against a next-PC model
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] EV = 32'hBFC0_0180;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0, instr_valid, stall = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0, instr, pc, pc_plus4;
    logic        jump_en = 1'b0, branch_en = 1'b0, jr_en = 1'b0, flush, addr_err;
    logic [25:0] jump_index = 26'd0;
    logic [31:0] branch_off = 32'd0, jr_addr = 32'd0;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_pc;
    logic        exp_flush, exp_err;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
        .jump_en(jump_en), .jump_index(jump_index), .branch_en(branch_en),
        .branch_off(branch_off), .jr_en(jr_en), .jr_addr(jr_addr),
        .flush(flush), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // {addr_err, flush, next_pc} from the redirect rules
    function automatic logic [33:0] model_next(input logic [31:0] cur, input bit j_r, input logic [31:0] jra,
                                               input bit j, input logic [25:0] ji, input bit b, input logic [31:0] bo);
        logic [31:0] p4;
        p4 = cur + 32'd4;
`ifdef ALIGN_CHECK_EN
        if (j_r && (jra % 4) != 0) return {2'b11, EV};
`endif
        if (j_r) return {2'b01, (jra / 4) * 4};
        if (j) return {2'b01, (p4 & 32'hF000_0000) | (32'(ji) * 4)};
        if (b) return {2'b01, p4 + bo * 4};
        return {2'b00, p4};
    endfunction

    task automatic clear_ins();
        jr_en = 0; jump_en = 0; branch_en = 0; stall = 0;
    endtask

    // wait (bounded) for a request, then answer after wt idle cycles; addr is x on timeout
    task automatic do_fetch(input int wt, output logic [31:0] addr);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (imem_req !== 1'b1) begin addr = 'x; return; end
        addr = imem_addr;
        repeat (wt) @(negedge clk);
        imem_ack = 1; imem_rdata = mem_word(addr);
        @(negedge clk);
        imem_ack = 0; imem_rdata = $urandom;
    endtask

    // accept the current instruction with the given redirect inputs; updates expected state
    task automatic do_issue(input bit j_r, input logic [31:0] jra, input bit j, input logic [25:0] ji,
                            input bit b, input logic [31:0] bo);
        logic [33:0] r;
        r = model_next(exp_pc, j_r, jra, j, ji, b, bo);
        {exp_err, exp_flush, exp_pc} = r;
        jr_en = j_r; jr_addr = jra; jump_en = j; jump_index = ji; branch_en = b; branch_off = bo; stall = 0;
        @(negedge clk);
        clear_ins();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 0;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_tests++; if (pc !== RV) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, RV); end
        n_tests++; if (instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
        n_tests++; if ({flush, addr_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%b exp=00", {flush, addr_err}); end
    endtask

    task automatic test_boot();
        logic [31:0] a;
        rst = 0;
        exp_pc = RV;
        do_fetch(0, a);
        n_tests++; if (a !== RV) begin n_fail++; $display("FAIL boot_addr got=%h exp=%h", a, RV); end
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL boot_valid got=%b exp=1", instr_valid); end
        n_tests++; if (instr !== mem_word(RV)) begin n_fail++; $display("FAIL boot_instr got=%h exp=%h", instr, mem_word(RV)); end
        n_tests++; if (pc_plus4 !== RV + 4) begin n_fail++; $display("FAIL boot_pc4 got=%h exp=%h", pc_plus4, RV + 4); end
        do_issue(0, 0, 0, 0, 0, 0);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid_drop got=%b exp=0", instr_valid); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL boot_seq_flush got=%b exp=0", flush); end
        do_fetch(0, a);
        n_tests++; if (a !== 32'hBFC0_0004) begin n_fail++; $display("FAIL boot_second_addr got=%h exp=bfc00004", a); end
        do_issue(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jump();
        logic [31:0] a;
        do_fetch(1, a);
        do_issue(1, 32'h0040_1000, 0, 0, 0, 0);
        do_fetch(0, a);
        n_tests++; if (a !== 32'h0040_1000) begin n_fail++; $display("FAIL jr_setup_addr got=%h exp=00401000", a); end
        do_issue(0, 0, 1, 26'h0000100, 0, 0);
        n_tests++; if (imem_addr !== 32'h0000_0400 || imem_req !== 1'b1) begin n_fail++; $display("FAIL jump_addr got=%h req=%b exp=00000400", imem_addr, imem_req); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush got=%b exp=1", flush); end
        @(negedge clk);
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jump_flush_pulse got=%b exp=0", flush); end
        do_fetch(0, a);
        do_issue(1, 32'h0040_0010, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        logic [31:0] a;
        do_fetch(2, a);
        n_tests++; if (a !== 32'h0040_0010) begin n_fail++; $display("FAIL branch_setup_addr got=%h exp=00400010", a); end
        do_issue(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
        n_tests++; if (imem_addr !== 32'h0040_000C) begin n_fail++; $display("FAIL branch_back got=%h exp=0040000c", imem_addr); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL branch_flush got=%b exp=1", flush); end
        do_fetch(0, a);
        do_issue(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        do_fetch(0, a);
        n_tests++; if (a !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup got=%h exp=fffffffc", a); end
        n_tests++; if (pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4); end
        do_issue(0, 0, 0, 0, 0, 0);
        n_tests++; if (imem_addr !== 32'd0 || flush !== 1'b0) begin n_fail++; $display("FAIL seq_wrap got=%h flush=%b exp=0", imem_addr, flush); end
    endtask

    task automatic test_stall_jr();
        logic [31:0] a, held_pc, held_instr;
        do_fetch(0, a);
        held_pc = pc; held_instr = instr;
        n_tests++; if (held_pc !== exp_pc) begin n_fail++; $display("FAIL stall_pc_entry got=%h exp=%h", held_pc, exp_pc); end
        jr_en = 1; jr_addr = 32'h1000_0000; jump_en = 1; jump_index = 26'h3FFFFFF; branch_en = 1; branch_off = 32'd7;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1; imem_rdata = 32'hDEAD_0000 + i;
            @(negedge clk);
            n_tests++;
            if (pc !== held_pc || instr !== held_instr || instr_valid !== 1'b1 || imem_req !== 1'b0 || flush !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold_%0d pc=%h instr=%h valid=%b req=%b flush=%b exp pc=%h instr=%h", i, pc, instr, instr_valid, imem_req, flush, held_pc, held_instr);
            end
        end
        imem_ack = 0;
        do_issue(1, 32'h1000_0000, 1, 26'h3FFFFFF, 1, 32'd7);
        n_tests++; if (imem_addr !== 32'h1000_0000 || flush !== 1'b1) begin n_fail++; $display("FAIL jr_priority got=%h flush=%b exp=10000000", imem_addr, flush); end
    endtask

    task automatic test_align();
        logic [31:0] a, want;
        logic        want_err;
`ifdef ALIGN_CHECK_EN
        want = EV; want_err = 1;
`else
        want = 32'h1000_0000; want_err = 0;
`endif
        do_fetch(0, a);
        do_issue(1, 32'h1000_0002, 1, 26'h1, 0, 0);
        n_tests++; if (imem_addr !== want) begin n_fail++; $display("FAIL align_target got=%h exp=%h", imem_addr, want); end
        n_tests++; if (addr_err !== want_err || flush !== 1'b1) begin n_fail++; $display("FAIL align_err got=%b flush=%b exp=%b", addr_err, flush, want_err); end
        @(negedge clk);
        n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL align_err_pulse got=%b exp=0", addr_err); end
    endtask

    task automatic test_rst_mid_fetch();
        logic [31:0] a;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req got=%b exp=1", imem_req); end
        rst = 1;
        #1;
        n_tests++; if (imem_req !== 1'b0 || pc !== RV) begin n_fail++; $display("FAIL midrst_drop req=%b pc=%h exp 0/%h", imem_req, pc, RV); end
        @(negedge clk);
        imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 0; rst = 0;
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== RV || instr !== 32'd0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_refetch req=%b addr=%h instr=%h valid=%b exp 1/%h/0/0", imem_req, imem_addr, instr, instr_valid, RV);
        end
        exp_pc = RV;
        do_fetch(1, a);
        n_tests++; if (instr !== mem_word(RV)) begin n_fail++; $display("FAIL midrst_instr got=%h exp=%h", instr, mem_word(RV)); end
        do_issue(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a, jra, bo, held;
        logic [25:0] ji;
        bit          jr, j, b;
        int          ns;
        for (int k = 0; k < 60; k++) begin
            do_fetch($urandom_range(0, 3), a);
            n_tests++; if (a !== exp_pc) begin n_fail++; $display("FAIL rnd_addr_%0d got=%h exp=%h", k, a, exp_pc); end
            n_tests++; if (instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_instr_%0d got=%h exp=%h", k, instr, mem_word(exp_pc)); end
            held = instr;
            ns = $urandom_range(0, 2);
            for (int s = 0; s < ns; s++) begin
                stall = 1; jr_en = $urandom; jump_en = $urandom; branch_en = $urandom; jr_addr = $urandom;
                @(negedge clk);
                n_tests++; if (pc !== exp_pc || instr !== held || flush !== 1'b0) begin n_fail++; $display("FAIL rnd_stall_%0d pc=%h instr=%h flush=%b", k, pc, instr, flush); end
            end
            jr = ($urandom_range(0, 3) == 0); j = $urandom; b = $urandom;
            jra = $urandom; ji = 26'($urandom);
            bo = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
            do_issue(jr, jra, j, ji, b, bo);
            n_tests++; if (flush !== exp_flush || addr_err !== exp_err) begin n_fail++; $display("FAIL rnd_pulse_%0d flush=%b err=%b exp=%b/%b", k, flush, addr_err, exp_flush, exp_err); end
        end
    endtask

    initial begin
        clear_ins();
        test_reset();
        test_boot();
        test_jump();
        test_branch();
        test_stall_jr();
        test_align();
        test_rst_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
